cp0_regfile_p: RTL

Parametrised coprocessor-0 register file for the MIPS pipeline: holds Count, Compare, Status, Cause, EPC, BadVAddr, PRId and Config. It also generates the precise-interrupt request to the exception stage. It sits beside the memory/writeback stage, takes the resolved exception of the committing instruction, and serves `mfc0` and `mtc0`. Over the previous CP0 it adds these:
- configurable hardware-interrupt width;
- a divided Count clock;
- a latched timer-interrupt bit;
- write masks on Status and Cause;
- uniform EXL nesting;
- an interrupt-pending output.

---
 rtl/cp0_regfile_p.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/cp0_regfile_p.sv
// cp0_regfile_p
// Coprocessor-0 register file for the MIPS pipeline. Holds Count, Compare,
// Status, Cause, EPC, BadVAddr and the read-only PRId/Config words. It takes
// the resolved exception of the committing instruction, serves mfc0/mtc0,
// and raises the precise-interrupt request to the exception stage.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   we_i, waddr_i     mtc0 write enable and register number
//   data_i            mtc0 write data
//   raddr_i, data_o   mfc0 register number and combinational read data
//   int_i             level hardware interrupts (already synchronised)
//   exc_valid_i       committing instruction takes an exception
//   exc_code_i        resolved ExcCode
//   exc_pc_i          PC of the excepting instruction
//   exc_bd_i          excepting instruction sits in a delay slot
//   exc_badvaddr_i    faulting address for AdEL/AdES
//   eret_i            eret commits
//   status_o, cause_o, epc_o  live register values
//   int_pending_o     an enabled interrupt is pending
module cp0_regfile_p #(
    parameter int unsigned HW_INT_NUM   = 6,
    parameter int unsigned COUNT_DIV    = 2,
    parameter logic [31:0] PRID_VALUE   = 32'h004C_0102,
    parameter logic [31:0] CONFIG_VALUE = 32'h0000_8000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic [4:0]            waddr_i,
    input  logic [4:0]            raddr_i,
    input  logic [31:0]           data_i,
    output logic [31:0]           data_o,
    input  logic [HW_INT_NUM-1:0] int_i,
    input  logic                  exc_valid_i,
    input  logic [4:0]            exc_code_i,
    input  logic [31:0]           exc_pc_i,
    input  logic                  exc_bd_i,
    input  logic [31:0]           exc_badvaddr_i,
    input  logic                  eret_i,
    output logic [31:0]           status_o,
    output logic [31:0]           cause_o,
    output logic [31:0]           epc_o,
    output logic                  int_pending_o
);

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;
    localparam logic [4:0] REG_PRID     = 5'd15;
    localparam logic [4:0] REG_CONFIG   = 5'd16;

    localparam int unsigned DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

    logic [DIV_W-1:0]      div;
    logic [31:0]           count;
    logic [31:0]           compare;
    logic                  ti;
    logic [7:0]            im;
    logic                  exl;
    logic                  ie;
    logic                  bd;
    logic [1:0]            ip_sw;
    logic [HW_INT_NUM-1:0] ip_hw;
    logic [4:0]            exc_code;
    logic [31:0]           epc;
    logic [31:0]           badvaddr;

    logic                  wr_count;
    logic                  wr_compare;
    logic                  wr_status;
    logic                  wr_cause;
    logic                  wr_epc;
    logic                  div_wrap;
    logic [5:0]            hw6;
    logic [7:0]            ip;
    logic [31:0]           status_val;
    logic [31:0]           cause_val;

    assign wr_count   = we_i && (waddr_i == REG_COUNT);
    assign wr_compare = we_i && (waddr_i == REG_COMPARE);
    assign wr_status  = we_i && (waddr_i == REG_STATUS);
    assign wr_cause   = we_i && (waddr_i == REG_CAUSE);
    assign wr_epc     = we_i && (waddr_i == REG_EPC);
    assign div_wrap   = (div == DIV_W'(COUNT_DIV - 1));

    // Count and its prescaler; an mtc0 Count restarts the prescale period.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            div   <= '0;
        end else if (wr_count) begin
            count <= data_i;
            div   <= '0;
        end else if (div_wrap) begin
            count <= count + 32'd1;
            div   <= '0;
        end else begin
            div   <= div + 1'b1;
        end
    end

    // TI latches on a Count/Compare match and only a Compare write clears it,
    // which also wins over a match in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            compare <= '0;
            ti      <= 1'b0;
        end else if (wr_compare) begin
            compare <= data_i;
            ti      <= 1'b0;
        end else if ((count == compare) && (compare != '0)) begin
            ti      <= 1'b1;
        end
    end

    // An exception discards a concurrent Status write entirely; otherwise
    // eret overrides only the EXL bit of a concurrent write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            im  <= '0;
            exl <= 1'b0;
            ie  <= 1'b0;
        end else if (exc_valid_i) begin
            exl <= 1'b1;
        end else begin
            if (wr_status) begin
                im  <= data_i[15:8];
                exl <= data_i[1];
                ie  <= data_i[0];
            end
            if (eret_i) begin
                exl <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ip_sw    <= '0;
            ip_hw    <= '0;
            bd       <= 1'b0;
            exc_code <= '0;
        end else begin
            ip_hw <= int_i;
            if (wr_cause) begin
                ip_sw <= data_i[9:8];
            end
            if (exc_valid_i) begin
                exc_code <= exc_code_i;
                if (!exl) begin
                    bd <= exc_bd_i;
                end
            end
        end
    end

    // With EXL already set the original return point is kept, so a
    // concurrent mtc0 EPC is then free to land.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            epc <= '0;
        end else if (exc_valid_i && !exl) begin
            epc <= exc_pc_i - (exc_bd_i ? 32'd4 : 32'd0);
        end else if (wr_epc) begin
            epc <= data_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            badvaddr <= '0;
        end else if (exc_valid_i && ((exc_code_i == 5'd4) || (exc_code_i == 5'd5))) begin
            badvaddr <= exc_badvaddr_i;
        end
    end

    // Hardware lines zero-extended to six so missing lines read 0; IP7 also
    // carries the timer interrupt.
    always_comb begin
        hw6 = 6'(ip_hw);
        ip  = {hw6[5] | ti, hw6[4:0], ip_sw};
    end

    always_comb begin
        status_val        = '0;
        status_val[22]    = 1'b1;
        status_val[15:8]  = im;
        status_val[1]     = exl;
        status_val[0]     = ie;

        cause_val         = '0;
        cause_val[31]     = bd;
        cause_val[30]     = ti;
        cause_val[15:8]   = ip;
        cause_val[6:2]    = exc_code;
    end

    always_comb begin
        data_o = '0;
        case (raddr_i)
            REG_BADVADDR: data_o = badvaddr;
            REG_COUNT:    data_o = count;
            REG_COMPARE:  data_o = compare;
            REG_STATUS:   data_o = status_val;
            REG_CAUSE:    data_o = cause_val;
            REG_EPC:      data_o = epc;
            REG_PRID:     data_o = PRID_VALUE;
            REG_CONFIG:   data_o = CONFIG_VALUE;
            default:      data_o = '0;
        endcase
    end

    assign status_o      = status_val;
    assign cause_o       = cause_val;
    assign epc_o         = epc;
    assign int_pending_o = ie && !exl && (|(ip & im));

endmodule
